// File: rtl/rf_sweep_engine.sv
// Register-file sweep engine: step k writes RF[base+k+2] = f(RF[base+k], RF[base+k+1]).
// One step per cycle (done count edges after start); start and host writes are ignored while busy.
module rf_sweep_engine #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] count,
    input  logic [2:0]        op,
    output logic              busy,
    output logic              done,
    output logic              ovf,
    output logic [ADDR_W-1:0] steps,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_waddr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic [ADDR_W-1:0] host_raddr,
    output logic [DATA_W-1:0] host_rdata
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int SH_W  = $clog2(DATA_W);
    localparam int MSB   = DATA_W - 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] rf [DEPTH];
    logic [ADDR_W-1:0] base_q, count_q;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] addr_a, addr_b, addr_w, steps_inc;
    logic [DATA_W-1:0] a, b, alu_res;
    logic              alu_ovf, accept;

    assign accept     = start && (state_q != RUN);
    assign steps_inc  = steps + ADDR_W'(1);
    assign addr_a     = base_q + steps;
    assign addr_b     = addr_a + ADDR_W'(1);
    assign addr_w     = addr_a + ADDR_W'(2);
    assign a          = rf[addr_a];
    assign b          = rf[addr_b];
    assign host_rdata = rf[host_raddr];
    assign busy       = (state_q == RUN);
    assign done       = (state_q == DONE);

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op_q)
            3'd0: begin
                alu_res = a + b;
                alu_ovf = (a[MSB] == b[MSB]) && (alu_res[MSB] != a[MSB]);
            end
            3'd1: begin
                alu_res = a - b;
                alu_ovf = (a[MSB] != b[MSB]) && (alu_res[MSB] != a[MSB]);
            end
            3'd2: alu_res = a & b;
            3'd3: alu_res = a | b;
            3'd4: alu_res = a ^ b;
            3'd5: alu_res = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            3'd6: alu_res = a << b[SH_W-1:0];
            default: alu_res = a >> b[SH_W-1:0];
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: if (steps_inc == count_q) state_d = DONE;
            default: if (start) state_d = (count == '0) ? DONE : RUN;
        endcase
    end

    // Host write and sweep write are exclusive by state, so one port per cycle suffices.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
            base_q  <= '0;
            count_q <= '0;
            op_q    <= '0;
            steps   <= '0;
            ovf     <= 1'b0;
        end else begin
            if (host_we && state_q != RUN) rf[host_waddr] <= host_wdata;
            if (state_q == RUN) begin
                rf[addr_w] <= alu_res;
                steps      <= steps_inc;
                if (alu_ovf) ovf <= 1'b1;
            end
            if (accept) begin
                base_q  <= base;
                count_q <= count;
                op_q    <= op;
                steps   <= '0;
                ovf     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rf_sweep_engine.sv
// Directed bench for rf_sweep_engine: each check is an immediate assertion against hand-computed values.
`timescale 1ns/1ps
module tb_rf_sweep_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  base = '0, count = '0;
    logic [2:0]  op = '0;
    logic        busy, done, ovf;
    logic [4:0]  steps;
    logic        host_we = 1'b0;
    logic [4:0]  host_waddr = '0, host_raddr = '0;
    logic [31:0] host_wdata = '0;
    logic [31:0] host_rdata;

    int errors = 0;
    int checks = 0;

    rf_sweep_engine #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .base(base), .count(count), .op(op),
        .busy(busy), .done(done), .ovf(ovf), .steps(steps),
        .host_we(host_we), .host_waddr(host_waddr), .host_wdata(host_wdata),
        .host_raddr(host_raddr), .host_rdata(host_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rf(input string tag, input int addr, input logic [31:0] exp);
        host_raddr = addr[4:0];
        #0.1;
        check(tag, host_rdata, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input int addr, input logic [31:0] data);
        host_we = 1'b1; host_waddr = addr[4:0]; host_wdata = data;
        tick(1);
        host_we = 1'b0;
    endtask

    task automatic go(input int b, input int c, input int o);
        start = 1'b1; base = b[4:0]; count = c[4:0]; op = o[2:0];
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        check("rst_steps", {27'd0, steps}, 32'd0);
        tick(2);
        rst = 1'b1;

        // Fibonacci: RF[k] = F(k)
        wr(0, 0);
        wr(1, 1);
        go(0, 30, 0);
        check("fib_busy0", {31'd0, busy}, 32'd1);
        tick(5);
        check("fib_steps5", {27'd0, steps}, 32'd5);
        tick(24);
        check("fib_busy29", {31'd0, busy}, 32'd1);
        check("fib_done29", {31'd0, done}, 32'd0);
        tick(1);
        check("fib_done30", {31'd0, done}, 32'd1);
        check("fib_busy30", {31'd0, busy}, 32'd0);
        check("fib_steps", {27'd0, steps}, 32'd30);
        check("fib_ovf", {31'd0, ovf}, 32'd0);
        chk_rf("fib_rf31", 31, 32'd1346269);
        chk_rf("fib_rf10", 10, 32'd55);

        // Address wrap
        wr(30, 5);
        wr(31, 7);
        go(30, 2, 0);
        tick(2);
        check("wrap_done", {31'd0, done}, 32'd1);
        chk_rf("wrap_rf0", 0, 32'd12);
        chk_rf("wrap_rf1", 1, 32'd19);

        // Signed add overflow, then count=0
        wr(0, 32'h7FFF_FFFF);
        wr(1, 32'd1);
        go(0, 1, 0);
        tick(1);
        chk_rf("ovf_rf2", 2, 32'h8000_0000);
        check("ovf_set", {31'd0, ovf}, 32'd1);
        go(0, 0, 0);
        check("zero_ovf", {31'd0, ovf}, 32'd0);
        check("zero_done", {31'd0, done}, 32'd1);
        check("zero_busy", {31'd0, busy}, 32'd0);
        check("zero_steps", {27'd0, steps}, 32'd0);
        chk_rf("zero_rf2", 2, 32'h8000_0000);
        chk_rf("zero_rf0", 0, 32'h7FFF_FFFF);

        // Busy guards: host write and restart during a running sweep
        wr(0, 32'd1);
        wr(1, 32'd1);
        go(0, 10, 0);
        tick(2);
        host_we = 1'b1; host_waddr = 5'd20; host_wdata = 32'hAA;
        start = 1'b1; base = 5'd5; count = 5'd3; op = 3'd1;
        tick(1);
        host_we = 1'b0; start = 1'b0;
        tick(6);
        check("guard_busy9", {31'd0, busy}, 32'd1);
        tick(1);
        check("guard_done", {31'd0, done}, 32'd1);
        check("guard_steps", {27'd0, steps}, 32'd10);
        chk_rf("guard_rf20", 20, 32'd6765);
        chk_rf("guard_rf11", 11, 32'd144);

        // Signed set-less-than
        wr(0, 32'hFFFF_FFFF);
        wr(1, 32'd0);
        go(0, 1, 5);
        tick(1);
        chk_rf("slt_rf2", 2, 32'd1);

        // Shift left / right
        wr(0, 32'd3);
        wr(1, 32'd4);
        go(0, 1, 6);
        tick(1);
        chk_rf("sll_rf2", 2, 32'd48);
        wr(0, 32'h80);
        wr(1, 32'h23);
        go(0, 1, 7);
        tick(1);
        chk_rf("srl_rf2", 2, 32'h10);

        // Signed sub overflow
        wr(0, 32'h8000_0000);
        wr(1, 32'd1);
        go(0, 1, 1);
        tick(1);
        chk_rf("sub_rf2", 2, 32'h7FFF_FFFF);
        check("sub_ovf", {31'd0, ovf}, 32'd1);

        // Host write in the same cycle as start is seen by step 0
        wr(1, 32'd20);
        host_we = 1'b1; host_waddr = 5'd0; host_wdata = 32'd10;
        go(0, 1, 0);
        host_we = 1'b0;
        tick(1);
        chk_rf("same_cyc_rf2", 2, 32'd30);
        check("same_cyc_ovf", {31'd0, ovf}, 32'd0);

        // Reset mid-sweep
        go(0, 10, 0);
        tick(3);
        rst = 1'b0;
        #1;
        check("mid_busy", {31'd0, busy}, 32'd0);
        check("mid_done", {31'd0, done}, 32'd0);
        check("mid_steps", {27'd0, steps}, 32'd0);
        check("mid_ovf", {31'd0, ovf}, 32'd0);
        for (int i = 0; i < 32; i++) chk_rf("mid_rf", i, 32'd0);
        tick(1);
        rst = 1'b1;
        go(3, 0, 0);
        check("post_rst_done", {31'd0, done}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rf_sweep_engine.md
RF_SWEEP_ENGINE -- requirements
Module: rf_sweep_engine

Interface
REQ-001 Parameter DATA_W, default 32, data word width in bits (power of two, 8..64).
REQ-002 Parameter ADDR_W, default 5, register address width; DEPTH = 2**ADDR_W entries.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request a sweep; sampled on rising edge.
REQ-006 base  input  ADDR_W  first source address, latched on accepted start.
REQ-007 count  input  ADDR_W  number of steps, latched on accepted start.
REQ-008 op  input  3  ALU operation, latched on accepted start.
REQ-009 busy  output  1  high while a sweep is running.
REQ-010 done  output  1  high from sweep completion until the next accepted start.
REQ-011 ovf  output  1  sticky signed overflow of add/sub during the current sweep.
REQ-012 steps  output  ADDR_W  steps completed in the current sweep.
REQ-013 host_we  input  1  host write enable.
REQ-014 host_waddr  input  ADDR_W  host write address.
REQ-015 host_wdata  input  DATA_W  host write data.
REQ-016 host_raddr  input  ADDR_W  host read address.
REQ-017 host_rdata  output  DATA_W  combinational read of RF[host_raddr].

Function
REQ-018 The block SHALL contain a DEPTH x DATA_W register file (RF) with no hard-wired entries.
REQ-019 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-020 start SHALL be accepted only in IDLE or DONE; it SHALL latch base, count and op, clear steps and ovf, and enter RUN, or enter DONE directly when count = 0.
REQ-021 start in RUN SHALL be ignored.
REQ-022 In RUN, step k (k = 0..count-1, one step per cycle) SHALL read a = RF[base+k] and b = RF[base+k+1], then write RF[base+k+2] <= f(a,b); all addresses are modulo DEPTH.
REQ-023 Each step SHALL observe the writes of all earlier steps, giving sequential semantics even when writes wrap onto source entries.
REQ-024 Timing: for start accepted at edge N, the writes SHALL occur at edges N+1..N+count, and busy=0/done=1 SHALL hold after edge N+count.
REQ-025 op encoding: 0 add, 1 sub (a-b), 2 and, 3 or, 4 xor, 5 signed slt (result 1 or 0), 6 sll a by b[log2(DATA_W)-1:0], 7 srl by the same amount.
REQ-026 All results SHALL be truncated to DATA_W.
REQ-027 ovf SHALL set when add/sub signed overflow occurs in any step and stay set until the next accepted start.
REQ-028 steps SHALL increment once per completed step and hold its final value in DONE.
REQ-029 host_we SHALL write RF in IDLE/DONE and SHALL be ignored in RUN.
REQ-030 host_we and an accepted start in the same cycle: the host write SHALL complete first and be visible to step 0.
REQ-031 host_rdata SHALL be valid in every state, reflecting the current RF contents.

Reset
REQ-032 rst low SHALL immediately force IDLE, clear all RF entries to 0, and clear busy, done, ovf and steps to 0, including mid-sweep (the sweep is aborted).
REQ-033 After rst deasserts, the first start SHALL be acceptable on the next rising edge.

Verification
REQ-034 Fibonacci: host writes RF[0]=0, RF[1]=1; start base=0, count=30, op=0 -> RF[31]=1346269, RF[10]=55, done high 30 cycles after the start edge, ovf=0, steps=30.
REQ-035 Wrap: RF[30]=5, RF[31]=7; start base=30, count=2, op=0 -> RF[0]=12, RF[1]=19.
REQ-036 Overflow: RF[0]=0x7FFFFFFF, RF[1]=1; count=1, op=0 -> RF[2]=0x80000000, ovf=1; a following start with count=0 -> ovf=0, done after one edge, steps=0, no RF change.
REQ-037 Busy guards: during a count=10 sweep, host write RF[20]=0xAA and a second start -> RF[20] unchanged and sweep completes with original parameters; slt with RF[0]=0xFFFFFFFF, RF[1]=0 -> RF[2]=1.
REQ-038 Reset mid-run: rst low after 3 steps of a count=10 sweep -> busy=0, done=0, steps=0, host_rdata=0 for all addresses.
